rf_read_port: RTL and testbench

- Read side of the 16-bit register file, paired with the per-bit write-enabled storage cells.
- Takes the flattened register contents and returns two operands through one registered output stage with a valid/ready handshake.
- Forwards a same-cycle write to the reader (write bypass).
- Has a dump FSM that streams every register out in order, for debug and test access.

---
 rtl/rf_read_port_if.sv | 45 ++++
 rtl/rf_read_port.sv | 138 +++++++++++++
 tb/tb_rf_read_port.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_read_port_if.sv
// rf_read_port_if -- operand read request and registered output handshake
// of the register-file read port.
//
// Handshake rules, both channels:
//   * A request transfers on a cycle where rd_req && rd_ready. rd_ready is
//     combinational and may depend on rd_req's channel state, never on rd_req.
//   * An output word transfers on a cycle where out_valid && out_ready.
//     While out_valid && !out_ready, out_data_a/out_data_b/out_tag are held.
//
// Signals:
//   rd_req      requester -> port   operand read request
//   rd_ready    port -> requester   request accepted this cycle when high
//   rd_addr_a   requester -> port   operand A register address
//   rd_addr_b   requester -> port   operand B register address
//   out_valid   port -> consumer    output stage holds valid data
//   out_ready   consumer -> port    consumer takes the output word
//   out_data_a  port -> consumer    operand A or dump word
//   out_data_b  port -> consumer    operand B (0 during a dump)
//   out_tag     port -> consumer    register address of out_data_a
//
// Modports: master = requester/consumer side, slave = the read port.
interface rf_read_port_if #(
  parameter int W  = 16,
  parameter int AW = 3
);
  logic          rd_req;
  logic          rd_ready;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data_a;
  logic [W-1:0]  out_data_b;
  logic [AW-1:0] out_tag;

  modport master (
    output rd_req, rd_addr_a, rd_addr_b, out_ready,
    input  rd_ready, out_valid, out_data_a, out_data_b, out_tag
  );

  modport slave (
    input  rd_req, rd_addr_a, rd_addr_b, out_ready,
    output rd_ready, out_valid, out_data_a, out_data_b, out_tag
  );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port -- read side of the register file.
//
// Returns two operands per accepted request through one registered output
// stage (1-cycle latency), forwards a same-cycle snooped write (bypass), and
// has a dump FSM (IDLE -> DUMP -> DRAIN) that streams all NREG registers out
// in address order through the same output stage.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rf_q         flattened register contents, register i at [i*W +: W]
//   wr_en/wr_addr/wr_data  write-port snoop used for the bypass
//   dump_start   single-cycle pulse starting a full dump (IDLE only)
//   dump_busy    high while the dump FSM is not IDLE
//   dbg_state    current dump FSM state (debug)
//   bus          rf_read_port_if slave: read request + output handshake
//
// Build option: define RF_READ_R0_ZERO_EN to make register 0 always read 0
// (operands and dump, bypass included).
module rf_read_port #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREG*W-1:0] rf_q,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            dump_start,
  output logic            dump_busy,
  output logic [1:0]      dbg_state,
  rf_read_port_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DUMP  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          dump_load;
  logic          slot_free;
  logic          accept;

  logic          out_valid_q;
  logic [W-1:0]  out_a_q, out_b_q;
  logic [AW-1:0] out_tag_q;

  // Read value of every address, bypass applied. Addresses >= NREG stay 0.
  logic [W-1:0]  val [2**AW];

  always_comb begin
    for (int i = 0; i < 2**AW; i++) val[i] = '0;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en && wr_addr == AW'(i)) val[i] = wr_data;
      else                            val[i] = rf_q[i*W +: W];
    end
`ifdef RF_READ_R0_ZERO_EN
    val[0] = '0;
`endif
  end

  assign slot_free    = !out_valid_q || bus.out_ready;
  // dump_start wins over a same-cycle read request.
  assign bus.rd_ready = slot_free && (state == S_IDLE) && !dump_start;
  assign accept       = bus.rd_req && bus.rd_ready;

  // Dump FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Dump FSM: next state and load strobe
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dump_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (dump_start) begin
          state_nxt = S_DUMP;
          cnt_nxt   = '0;
        end
      end
      S_DUMP: begin
        if (slot_free) begin
          dump_load = 1'b1;
          cnt_nxt   = cnt + AW'(1);
          if (cnt == AW'(NREG-1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last word consumed (or never pending): back to idle.
        if (slot_free) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output stage: captures a snapshot; held while valid && !ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_tag_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_a_q     <= val[bus.rd_addr_a];
      out_b_q     <= val[bus.rd_addr_b];
      out_tag_q   <= bus.rd_addr_a;
    end else if (dump_load) begin
      out_valid_q <= 1'b1;
      out_a_q     <= val[cnt];
      out_b_q     <= '0;
      out_tag_q   <= cnt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data_a = out_a_q;
  assign bus.out_data_b = out_b_q;
  assign bus.out_tag    = out_tag_q;
  assign dump_busy      = (state != S_IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_rf_read_port.sv
module tb_rf_read_port;
  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;
`ifdef RF_READ_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NREG*W-1:0] rf_q;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              dump_start;
  logic              dump_busy;
  logic [1:0]        dbg_state;

  rf_read_port_if #(.W(W), .AW(AW)) bus ();

  rf_read_port #(.W(W), .NREG(NREG), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rf_q       (rf_q),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dbg_state  (dbg_state),
    .bus        (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_tag_q[$];

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.rd_req    = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    dump_start    = 1'b0;
  endtask

  task automatic set_ramp;
    for (int i = 0; i < NREG; i++) rf_q[i*W +: W] = W'(i * 16'h0101);
  endtask

  task automatic test_reset;
    rf_q          = '0;
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data_a !== 16'h0 || bus.out_data_b !== 16'h0 || bus.out_tag !== 3'd0) begin
      n_fail++; $display("FAIL reset_data: got a=%h b=%h tag=%0d expected 0/0/0", bus.out_data_a, bus.out_data_b, bus.out_tag);
    end
    n_checks++;
    if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", dump_busy); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.rd_ready); end
  endtask

  task automatic test_basic_read;
    rf_q[3*W +: W] = 16'h1234;
    rf_q[5*W +: W] = 16'hBEEF;
    bus.out_ready = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd5;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data_a !== 16'h1234 || bus.out_data_b !== 16'hBEEF || bus.out_tag !== 3'd3) begin
      n_fail++; $display("FAIL basic_read: got v=%b a=%h b=%h tag=%0d expected 1/1234/beef/3",
                         bus.out_valid, bus.out_data_a, bus.out_data_b, bus.out_tag);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got valid=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_bypass;
    rf_q[2*W +: W] = 16'h0000;
    bus.out_ready = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5;
    tick();
    n_checks++;
    if (bus.out_data_a !== 16'hA5A5 || bus.out_data_b !== 16'hA5A5) begin
      n_fail++; $display("FAIL bypass_hit: got a=%h b=%h expected a5a5/a5a5", bus.out_data_a, bus.out_data_b);
    end
    // write to another register must not disturb these operands
    bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd3;
    wr_addr = 3'd4; wr_data = 16'h7777;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.out_data_a !== 16'hBEEF || bus.out_data_b !== 16'h1234 || bus.out_tag !== 3'd5) begin
      n_fail++; $display("FAIL bypass_miss: got a=%h b=%h tag=%0d expected beef/1234/5", bus.out_data_a, bus.out_data_b, bus.out_tag);
    end
    tick();
  endtask

  task automatic test_backpressure;
    rf_q[3*W +: W] = 16'h1234;
    bus.out_ready = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd5;
    tick();
    for (int i = 0; i < 4; i++) begin
      rf_q[3*W +: W] = 16'h5555;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h6666;
      bus.rd_req = 1'b1; bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd3;
      #1;
      n_checks++;
      if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d: got %b expected 0", i, bus.rd_ready); end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data_a !== 16'h1234 || bus.out_data_b !== 16'hBEEF || bus.out_tag !== 3'd3) begin
        n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b a=%h b=%h tag=%0d expected 1/1234/beef/3",
                           i, bus.out_valid, bus.out_data_a, bus.out_data_b, bus.out_tag);
      end
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.rd_ready); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.rd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_after: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.rd_ready);
    end
  endtask

  task automatic test_back_to_back;
    set_ramp();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr_a = AW'(i); bus.rd_addr_b = AW'(7 - i);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data_a !== W'(i * 16'h0101) ||
          bus.out_data_b !== W'((7 - i) * 16'h0101) || bus.out_tag !== AW'(i)) begin
        n_fail++; $display("FAIL b2b%0d: got v=%b a=%h b=%h tag=%0d expected 1/%h/%h/%0d", i, bus.out_valid,
                           bus.out_data_a, bus.out_data_b, bus.out_tag, W'(i * 16'h0101), W'((7 - i) * 16'h0101), i);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dump;
    set_ramp();
    bus.out_ready = 1'b1;
    dump_start = 1'b1;
    #1;
    n_checks++;
    if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL dump_start_ready: got %b expected 0", bus.rd_ready); end
    tick();
    dump_start = 1'b0;
    n_checks++;
    if (dump_busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL dump_enter: got busy=%b valid=%b expected 1/0", dump_busy, bus.out_valid);
    end
    for (int i = 0; i < NREG; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== AW'(i) || bus.out_data_a !== W'(i * 16'h0101) ||
          bus.out_data_b !== 16'h0 || dump_busy !== 1'b1) begin
        n_fail++; $display("FAIL dump_word%0d: got v=%b tag=%0d a=%h b=%h busy=%b expected 1/%0d/%h/0/1", i,
                           bus.out_valid, bus.out_tag, bus.out_data_a, bus.out_data_b, dump_busy, i, W'(i * 16'h0101));
      end
    end
    tick();
    n_checks++;
    if (dump_busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL dump_end: got busy=%b valid=%b expected 0/0", dump_busy, bus.out_valid);
    end
  endtask

  task automatic test_dump_backpressure;
    set_ramp();
    bus.out_ready = 1'b1;
    dump_start = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd1; bus.rd_addr_b = 3'd1;
    #1;
    n_checks++;
    if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL dbp_collide_ready: got %b expected 0", bus.rd_ready); end
    tick();
    idle_inputs();
    n_checks++;
    if (bus.out_valid !== 1'b0 || dump_busy !== 1'b1) begin
      n_fail++; $display("FAIL dbp_collide: got valid=%b busy=%b expected 0/1", bus.out_valid, dump_busy);
    end
    exp_q.delete(); exp_tag_q.delete();
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back(W'(i * 16'h0101));
      exp_tag_q.push_back(AW'(i));
    end
    for (int cyc = 0; cyc < 60 && (exp_q.size() > 0 || dump_busy); cyc++) begin
      bus.out_ready = (cyc % 2 == 0);
      dump_start    = (cyc == 3);   // must be ignored outside IDLE
      bus.rd_req    = (cyc == 5);   // must not be accepted during a dump
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL dbp_extra: unexpected word tag=%0d a=%h", bus.out_tag, bus.out_data_a);
        end else if (bus.out_tag !== exp_tag_q[0] || bus.out_data_a !== exp_q[0] || bus.out_data_b !== 16'h0) begin
          n_fail++; $display("FAIL dbp_word: got tag=%0d a=%h b=%h expected %0d/%h/0",
                             bus.out_tag, bus.out_data_a, bus.out_data_b, exp_tag_q[0], exp_q[0]);
        end
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
      end
      tick();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    n_checks++;
    if (exp_q.size() != 0 || dump_busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL dbp_done: got left=%0d busy=%b valid=%b expected 0/0/0", exp_q.size(), dump_busy, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_dump;
    set_ramp();
    bus.out_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || dump_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_dump: got valid=%b busy=%b expected 0/0", bus.out_valid, dump_busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== AW'(i) || bus.out_data_a !== W'(i * 16'h0101)) begin
        n_fail++; $display("FAIL rst_redump%0d: got v=%b tag=%0d a=%h expected 1/%0d/%h", i,
                           bus.out_valid, bus.out_tag, bus.out_data_a, i, W'(i * 16'h0101));
      end
    end
    for (int i = 0; i < 12 && dump_busy; i++) tick();
    n_checks++;
    if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL rst_redump_end: got busy=%b expected 0", dump_busy); end
    tick();
  endtask

  task automatic test_r0;
    logic [W-1:0] e;
    set_ramp();
    rf_q[0 +: W] = 16'hFFFF;
    bus.out_ready = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd1;
    tick();
    e = R0Z ? 16'h0000 : 16'hFFFF;
    n_checks++;
    if (bus.out_data_a !== e || bus.out_data_b !== 16'h0101) begin
      n_fail++; $display("FAIL r0_plain: got a=%h b=%h expected %h/0101", bus.out_data_a, bus.out_data_b, e);
    end
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1357;
    tick();
    idle_inputs();
    e = R0Z ? 16'h0000 : 16'h1357;
    n_checks++;
    if (bus.out_data_a !== e || bus.out_data_b !== e) begin
      n_fail++; $display("FAIL r0_bypass: got a=%h b=%h expected %h/%h", bus.out_data_a, bus.out_data_b, e, e);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_dump();
    test_dump_backpressure();
    test_reset_mid_dump();
    test_r0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
